// File: rtl/rng_pkg.sv
// Shared definitions for the random-number arbiter: FSM encoding, LFSR taps, safe seed.
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DELIVER
    } rng_state_e;

    // Feedback taps of the right-shifting 16-bit LFSR
    localparam int TAP_A = 0;
    localparam int TAP_B = 2;
    localparam int TAP_C = 3;
    localparam int TAP_D = 5;

    localparam logic [15:0] RNG_SAFE_SEED = 16'hACE1;

    // A zero seed would lock the LFSR, so it is replaced by the safe seed
    function automatic logic [15:0] fix_seed(input logic [15:0] s, input logic [15:0] safe);
        return (s == 16'h0000) ? safe : s;
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Combinational next-state function of the 16-bit right-shifting LFSR.
module lfsr16_step (
    input  logic [15:0] cur,
    output logic [15:0] nxt
);
    import rng_pkg::*;

    assign nxt = {cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D], cur[15:1]};

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out LFSR random values to NREQ requesters.
// Optional macro RNG_FREE_RUN_EN: the LFSR also advances on every IDLE cycle.
module rng_arbiter #(
    parameter int          NREQ      = 3,
    parameter int          STEPS     = 4,
    parameter logic [15:0] SAFE_SEED = rng_pkg::RNG_SAFE_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     seed,
    input  logic            seed_load,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [15:0]     rnd_data,
    output logic            busy
);
    import rng_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rng_state_e    state;
    rng_state_e    state_next;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [IW-1:0] owner;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_after;
    logic [IW-1:0] grant_idx;
    logic          grant_found;
    logic [3:0]    step_cnt;
    logic          delivering;
    int            cand;

    lfsr16_step u_step (
        .cur (lfsr),
        .nxt (lfsr_next)
    );

    // Scan downward so the last hit, i.e. the first requester at or after rr_ptr, wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr) + i) % NREQ;
            if (req[cand[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    assign rr_after   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
    assign delivering = (state == DELIVER) && !seed_load;
    assign busy       = (state != IDLE);
    assign rnd_data   = delivering ? lfsr : 16'h0000;

    always_comb begin
        ack = '0;
        if (delivering) begin
            ack[owner] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (seed_load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (grant_found) state_next = MIX;
                MIX:     if (step_cnt == 4'(STEPS - 1)) state_next = DELIVER;
                DELIVER: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A reseed aborts any transaction silently and leaves rr_ptr untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= SAFE_SEED;
            owner    <= '0;
            rr_ptr   <= '0;
            step_cnt <= '0;
        end else if (seed_load) begin
            lfsr <= fix_seed(seed, SAFE_SEED);
        end else begin
            case (state)
                IDLE: begin
`ifdef RNG_FREE_RUN_EN
                    lfsr <= lfsr_next;
`else
                    lfsr <= lfsr;
`endif
                    if (grant_found) begin
                        owner    <= grant_idx;
                        step_cnt <= '0;
                    end
                end
                MIX: begin
                    lfsr     <= lfsr_next;
                    step_cnt <= step_cnt + 4'd1;
                end
                DELIVER: begin
                    rr_ptr <= rr_after;
                end
                default: begin
                    step_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: transaction-level reference model plus directed scenarios.
module tb_rng_arbiter;

    localparam int NREQ  = 3;
    localparam int STEPS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            seed_load = 1'b0;
    logic [15:0]     seed = 16'h0000;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] ack;
    logic [15:0]     rnd_data;
    logic            busy;

    rng_arbiter #(.NREQ(NREQ), .STEPS(STEPS), .SAFE_SEED(16'hACE1)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed      (seed),
        .seed_load (seed_load),
        .req       (req),
        .ack       (ack),
        .rnd_data  (rnd_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] ackv;
        logic [15:0]     data;
        int              cyc;
    } delivery_t;

    delivery_t       expq[$];
    delivery_t       acklog[$];
    delivery_t       got;
    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    logic [15:0]     mlfsr;
    int              mcount = 0;
    int              mowner = 0;
    int              mptr = 0;
    int              winner;
    logic [NREQ-1:0] ev;

    // Value after n shifts: new top bit is the parity of taps 0,2,3,5 (mask 0x002D)
    function automatic logic [15:0] ref_value(input logic [15:0] start, input int n);
        logic [15:0] s;
        s = start;
        repeat (n) s = {^(s & 16'h002D), s[15:1]};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic sl, input logic [15:0] s, input int n);
        @(posedge clk);
        #1;
        req       = r;
        seed_load = sl;
        seed      = s;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: one expected delivery per grant, withdrawn if a reseed aborts it
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mlfsr  = 16'hACE1;
            mcount = 0;
            mptr   = 0;
            mowner = 0;
            expq.delete();
        end else if (seed_load) begin
            mlfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
            if (mcount > 0 && expq.size() > 0) void'(expq.pop_back());
            mcount = 0;
        end else if (mcount > 0) begin
            mcount = mcount - 1;
            if (mcount == 0) mptr = (mowner + 1) % NREQ;
        end else if (req != '0) begin
            winner = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (winner < 0 && req[(mptr + k) % NREQ]) winner = (mptr + k) % NREQ;
            end
            mowner = winner;
            mlfsr  = ref_value(mlfsr, STEPS);
            mcount = STEPS + 1;
            ev = '0;
            ev[winner] = 1'b1;
            expq.push_back(delivery_t'{ev, mlfsr, cyc + STEPS});
        end
    end

    // Monitor: compares every presented ack against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset ack", ack, 0);
            checkOutput("reset busy", busy, 0);
            checkOutput("reset rnd_data", rnd_data, 0);
        end else begin
            checkOutput("busy", busy, mcount > 0);
            if (ack != '0) begin
                acklog.push_back(delivery_t'{ack, rnd_data, cyc});
                if (expq.size() == 0) begin
                    checkOutput("unexpected ack", ack, 0);
                end else begin
                    got = expq.pop_front();
                    checkOutput("ack vector", ack, got.ackv);
                    checkOutput("rnd_data", rnd_data, got.data);
                    checkOutput("ack cycle", cyc, got.cyc);
                end
            end else begin
                checkOutput("rnd_data idle", rnd_data, 0);
                if (expq.size() > 0 && expq[0].cyc < cyc) begin
                    checkOutput("missing ack", 0, expq[0].ackv);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    int              n0;
    int              base;
    logic [31:0]     rv;
    logic [31:0]     sv;
    logic [NREQ-1:0] rr_exp [4];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset busy", busy, 0);
        checkOutput("post-reset ack", ack, 0);

        // Seed 0001 then a single request from requester 0
        applyStimulus('0, 1'b1, 16'h0001, 1);
        applyStimulus(3'b001, 1'b0, 16'h0000, 1);
        base = cyc;
        n0 = acklog.size();
        applyStimulus('0, 1'b0, 16'h0000, 10);
        checkOutput("seed1 ack count", acklog.size() - n0, 1);
        if (acklog.size() > n0) begin
            checkOutput("seed1 ack", acklog[n0].ackv, 3'b001);
            checkOutput("seed1 data", acklog[n0].data, 16'h1000);
            checkOutput("seed1 latency", acklog[n0].cyc - base, 5);
        end

        // Zero seed falls back to ACE1
        applyStimulus('0, 1'b1, 16'h0000, 1);
        applyStimulus(3'b010, 1'b0, 16'h0000, 1);
        n0 = acklog.size();
        applyStimulus('0, 1'b0, 16'h0000, 10);
        checkOutput("zero-seed ack count", acklog.size() - n0, 1);
        if (acklog.size() > n0) begin
            checkOutput("zero-seed data", acklog[n0].data, ref_value(16'hACE1, STEPS));
        end

        // All requesters held after a reset: round-robin order and spacing
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n0 = acklog.size();
        applyStimulus(3'b111, 1'b0, 16'h0000, 26);
        applyStimulus('0, 1'b0, 16'h0000, 10);
        checkOutput("rr ack count >= 4", acklog.size() - n0 >= 4, 1);
        for (int k = 0; k < 4; k++) begin
            if (acklog.size() > n0 + k) begin
                checkOutput($sformatf("rr order %0d", k), acklog[n0 + k].ackv, rr_exp[k]);
                if (k > 0) checkOutput($sformatf("rr spacing %0d", k),
                                       acklog[n0 + k].cyc - acklog[n0 + k - 1].cyc, 6);
            end
        end

        // Reseed during the second MIX cycle aborts, then the held request restarts
        n0 = acklog.size();
        applyStimulus(3'b001, 1'b0, 16'h0000, 2);
        applyStimulus(3'b001, 1'b1, 16'h1234, 1);
        applyStimulus(3'b001, 1'b0, 16'h0000, 1);
        base = cyc;
        @(negedge clk);
        checkOutput("busy after abort", busy, 0);
        checkOutput("no ack on abort", acklog.size() - n0, 0);
        applyStimulus('0, 1'b0, 16'h0000, 10);
        checkOutput("restart ack count", acklog.size() - n0, 1);
        if (acklog.size() > n0) begin
            checkOutput("restart data", acklog[n0].data, ref_value(16'h1234, STEPS));
            checkOutput("restart latency", acklog[n0].cyc - base, 5);
        end

        // Owner drops its request during the first MIX cycle
        n0 = acklog.size();
        applyStimulus(3'b100, 1'b0, 16'h0000, 1);
        applyStimulus('0, 1'b0, 16'h0000, 12);
        checkOutput("dropped-req ack count", acklog.size() - n0, 1);
        if (acklog.size() > n0) checkOutput("dropped-req ack", acklog[n0].ackv, 3'b100);

        // Reset asserted during DELIVER suppresses the ack
        n0 = acklog.size();
        applyStimulus(3'b010, 1'b0, 16'h0000, 1);
        applyStimulus('0, 1'b0, 16'h0000, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst-in-deliver ack", ack, 0);
        checkOutput("rst-in-deliver busy", busy, 0);
        checkOutput("rst-in-deliver rnd_data", rnd_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus('0, 1'b0, 16'h0000, 6);
        checkOutput("rst-in-deliver ack count", acklog.size() - n0, 0);

        // Randomized traffic with occasional reseeds, checked by the scoreboard
        repeat (400) begin
            rv = $urandom;
            sv = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            applyStimulus(rv[NREQ-1:0], $urandom_range(0, 19) == 0, sv[15:0], $urandom_range(1, 3));
        end
        applyStimulus('0, 1'b0, 16'h0000, 12);
        checkOutput("scoreboard drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of random-number requesters (2..8).
REQ-002 SHALL have parameter STEPS, default 4, number of LFSR shifts per delivered value (1..15).
REQ-003 SHALL have parameter SAFE_SEED, default 16'hACE1, the value substituted for an all-zero seed.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port seed, input, 16, the reseed value.
REQ-007 SHALL have port seed_load, input, 1, loads seed into the LFSR when high.
REQ-008 SHALL have port req, input, NREQ, level request per requester, held until acknowledged.
REQ-009 SHALL have port ack, output, NREQ, one-hot single-cycle delivery strobe.
REQ-010 SHALL have port rnd_data, output, 16, random value, valid only while ack is nonzero.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL hold a 16-bit LFSR state: shift right, new bit15 = s[0]^s[2]^s[3]^s[5].
REQ-013 SHALL implement FSM states IDLE, MIX and DELIVER.
REQ-014 IDLE: if any req bit is set, SHALL latch the winning index into owner, clear step_cnt, and go to MIX.
REQ-015 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo NREQ; after delivery, rr_ptr = owner+1 mod NREQ.
REQ-016 MIX: SHALL shift the LFSR once per cycle and increment step_cnt; after STEPS shifts, go to DELIVER.
REQ-017 DELIVER: SHALL assert ack[owner] for exactly one cycle with rnd_data = LFSR state, then go to IDLE.
REQ-018 Latency: a req sampled in IDLE at edge t SHALL receive ack during cycle t+STEPS+1; the arbiter SHALL be able to accept a new request on the cycle after DELIVER.
REQ-019 If the owner drops req during MIX, the transaction SHALL still complete; the ack is delivered and is not re-issued.
REQ-020 seed_load SHALL take priority in every state: it loads the LFSR, forces IDLE, and drops the in-flight transaction without an ack; rr_ptr is unchanged.
REQ-021 A seed of 16'h0000 SHALL load SAFE_SEED instead, so the LFSR never holds zero.
REQ-022 rnd_data SHALL be 16'h0000 whenever ack is 0.

Reset
REQ-023 rst SHALL set the LFSR to SAFE_SEED, the state to IDLE, owner, rr_ptr and step_cnt to 0, ack to 0 and busy to 0.
REQ-024 rst asserted mid-MIX or mid-DELIVER SHALL abort the transaction with no ack pulse.

Configuration
REQ-025 With RNG_FREE_RUN_EN defined, the LFSR SHALL also shift every IDLE cycle, so player timing adds entropy.
REQ-026 Without RNG_FREE_RUN_EN, the LFSR SHALL shift only in MIX, so sequences are fully repeatable from seed.

Structure
REQ-027 A shared package rng_pkg SHALL hold the FSM state encoding, the tap positions, and the SAFE_SEED constant.
REQ-028 A sub-module lfsr16_step SHALL compute the next LFSR state combinationally; rng_arbiter owns the state register, FSM and arbiter.

Verification (RNG_FREE_RUN_EN undefined, NREQ=3, STEPS=4)
REQ-029 seed=16'h0001 with seed_load, then req=3'b001 -> ack=3'b001 exactly 5 cycles later with rnd_data=16'h1000.
REQ-030 seed=16'h0000 with seed_load -> internal state equals 16'hACE1; the next delivery matches the model reseeded with ACE1.
REQ-031 req=3'b111 held continuously -> acks appear in order 001, 010, 100, 001, each 6 cycles apart.
REQ-032 seed_load pulsed in the 2nd MIX cycle of a transaction -> no ack, busy=0 on the next cycle, and the held request restarts from IDLE.
REQ-033 rst asserted during DELIVER -> ack=0 in that cycle, with all outputs at reset values.
REQ-034 Owner drops req in the 1st MIX cycle -> a single ack is still issued, and no second ack follows.
